// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the 32x32 register file: load-over-ALU priority with ALU
// starvation relief, a registered write port, and a pending-write scoreboard.
module rf_wb_arbiter #(
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   output logic        issue_ready,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        ld_valid,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_data,
   output logic        ld_ready,
   output logic        rf_wen,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   input  logic [4:0]  chk_rs1,
   input  logic [4:0]  chk_rs2,
   output logic        hazard,
   output logic [31:0] busy
);

   logic [3:0]  starve_cnt;
   logic        force_alu;
   logic        hs;
   logic [4:0]  win_rd;
   logic [31:0] win_data;
   logic [31:0] set_vec;
   logic [31:0] clr_vec;
   logic [31:0] busy_nxt;

   assign force_alu = alu_valid && (starve_cnt == 4'(STARVE_MAX));

   always_comb begin
      alu_ready = 1'b0;
      ld_ready  = 1'b0;
      if (!rst) begin
         ld_ready  = ld_valid && !force_alu;
         alu_ready = alu_valid && (force_alu || !ld_valid);
      end
   end

   assign hs       = alu_ready || ld_ready;
   assign win_rd   = ld_ready ? ld_rd : alu_rd;
   assign win_data = ld_ready ? ld_data : alu_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!alu_valid || alu_ready) begin
         starve_cnt <= '0;
      end else if (starve_cnt != 4'(STARVE_MAX)) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_wen <= hs && (win_rd != 5'd0);
         if (hs) begin
            rf_waddr <= win_rd;
            rf_wdata <= win_data;
         end
      end
   end

   assign issue_ready = !rst && ((issue_rd == 5'd0) || !busy[issue_rd]);

   // Set is ORed in after the clear so an issue colliding with a commit wins.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (issue_valid && issue_ready && (issue_rd != 5'd0))
         set_vec[issue_rd] = 1'b1;
      if (rf_wen)
         clr_vec[rf_waddr] = 1'b1;
      busy_nxt = (busy & ~clr_vec) | set_vec;
   end

   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= {busy_nxt[31:1], 1'b0};
   end

   assign hazard = ((chk_rs1 != 5'd0) && busy[chk_rs1]) ||
                   ((chk_rs2 != 5'd0) && busy[chk_rs2]);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, single write, starvation relief,
// x0 handling, WAW blocking, set-wins collision and reset during a write.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        ld_valid;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  chk_rs1;
   logic [4:0]  chk_rs2;
   logic        hazard;
   logic [31:0] busy;

   int unsigned nvec = 0;
   int unsigned nmis = 0;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.STARVE_MAX(3)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [4:0]  exp_addr [4];
   logic [31:0] exp_data [4];

   initial begin
      rst = 1'b1; issue_valid = 1'b0; issue_rd = '0;
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
      ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'h22;
      chk_rs1 = 5'd5; chk_rs2 = 5'd0;

      // reset with both sources valid
      #2;
      check("rst_alu_ready", 32'(alu_ready), 32'd0);
      check("rst_ld_ready", 32'(ld_ready), 32'd0);
      check("rst_issue_ready", 32'(issue_ready), 32'd0);
      tick(); tick();
      rst = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
      #1;
      check("rst_rf_wen", 32'(rf_wen), 32'd0);
      check("rst_busy", busy, 32'd0);
      check("rst_hazard", 32'(hazard), 32'd0);

      // single ALU write to x5
      issue_valid = 1'b1; issue_rd = 5'd5;
      #1 check("iss5_ready", 32'(issue_ready), 32'd1);
      tick();
      issue_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      #1;
      check("iss5_busy", busy, 32'h0000_0020);
      check("iss5_hazard", 32'(hazard), 32'd1);
      check("alu5_ready", 32'(alu_ready), 32'd1);
      check("alu5_ld_ready", 32'(ld_ready), 32'd0);
      tick();
      alu_valid = 1'b0;
      #1;
      check("alu5_wen", 32'(rf_wen), 32'd1);
      check("alu5_waddr", 32'(rf_waddr), 32'd5);
      check("alu5_wdata", rf_wdata, 32'hDEADBEEF);
      check("alu5_hazard_commit", 32'(hazard), 32'd1);
      tick();
      check("alu5_hazard_after", 32'(hazard), 32'd0);
      check("alu5_busy_after", busy, 32'd0);
      check("alu5_wen_after", 32'(rf_wen), 32'd0);
      check("alu5_wdata_hold", rf_wdata, 32'hDEADBEEF);

      // contention: expect L,L,L,A
      exp_addr = '{5'd10, 5'd11, 5'd12, 5'd20};
      exp_data = '{32'h1000, 32'h1001, 32'h1002, 32'hA1A1A1A1};
      alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA1A1A1A1;
      for (int k = 0; k < 4; k++) begin
         ld_valid = 1'b1; ld_rd = 5'(10 + k); ld_data = 32'h1000 + 32'(k);
         #1;
         check($sformatf("starve%0d_alu_ready", k), 32'(alu_ready), (k == 3) ? 32'd1 : 32'd0);
         check($sformatf("starve%0d_ld_ready", k), 32'(ld_ready), (k == 3) ? 32'd0 : 32'd1);
         if (k > 0) begin
            check($sformatf("starve%0d_waddr", k), 32'(rf_waddr), 32'(exp_addr[k-1]));
            check($sformatf("starve%0d_wdata", k), rf_wdata, exp_data[k-1]);
         end
         tick();
      end
      // load x13 still pending; new ALU op must lose again (counter cleared)
      alu_rd = 5'd21; alu_data = 32'hB2B2B2B2;
      #1;
      check("post_ld_ready", 32'(ld_ready), 32'd1);
      check("post_alu_ready", 32'(alu_ready), 32'd0);
      check("post_waddr", 32'(rf_waddr), 32'd20);
      check("post_wdata", rf_wdata, 32'hA1A1A1A1);
      tick();
      ld_valid = 1'b0; alu_valid = 1'b0;
      #1;
      check("post_ld_waddr", 32'(rf_waddr), 32'd13);
      check("post_ld_wen", 32'(rf_wen), 32'd1);
      tick();

      // x0 writeback and x0 issue
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
      #1 check("x0_alu_ready", 32'(alu_ready), 32'd1);
      tick();
      alu_valid = 1'b0;
      #1;
      check("x0_wen", 32'(rf_wen), 32'd0);
      check("x0_busy", busy, 32'd0);
      issue_valid = 1'b1; issue_rd = 5'd0;
      #1 check("x0_issue_ready", 32'(issue_ready), 32'd1);
      tick();
      issue_valid = 1'b0;
      #1 check("x0_issue_busy", busy, 32'd0);

      // WAW on x7
      issue_valid = 1'b1; issue_rd = 5'd7;
      tick();
      chk_rs1 = 5'd0; chk_rs2 = 5'd7;
      #1;
      check("waw_busy", busy, 32'h0000_0080);
      check("waw_blocked", 32'(issue_ready), 32'd0);
      check("waw_hazard_rs2", 32'(hazard), 32'd1);
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
      #1 check("waw_alu_ready", 32'(alu_ready), 32'd1);
      tick();
      alu_valid = 1'b0;
      #1;
      check("waw_commit_wen", 32'(rf_wen), 32'd1);
      check("waw_commit_blocked", 32'(issue_ready), 32'd0);
      tick();
      check("waw_cleared", busy, 32'd0);
      check("waw_now_ready", 32'(issue_ready), 32'd1);
      tick();
      issue_valid = 1'b0;
      #1 check("waw_reissued", busy, 32'h0000_0080);

      // set and clear of x9 on the same edge: set wins
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
      tick();
      alu_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd9;
      #1;
      check("sw_issue_ready", 32'(issue_ready), 32'd1);
      check("sw_waddr", 32'(rf_waddr), 32'd9);
      tick();
      issue_valid = 1'b0;
      #1 check("sw_busy", busy, 32'h0000_0280);

      // reset while a write is in flight
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
      tick();
      alu_valid = 1'b0; rst = 1'b1;
      #1 check("rmid_wen_inflight", 32'(rf_wen), 32'd1);
      tick();
      rst = 1'b0;
      chk_rs1 = 5'd9; chk_rs2 = 5'd7;
      #1;
      check("rmid_wen", 32'(rf_wen), 32'd0);
      check("rmid_busy", busy, 32'd0);
      check("rmid_waddr", 32'(rf_waddr), 32'd0);
      check("rmid_hazard", 32'(hazard), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
